sort_frame_drain: RTL
=====================

# sort_frame_drain

Downstream stage of the 10-input combinational sorting network. Captures one sorted 10-word frame (`sort_0`…`sort_9`) per accepted handshake into a two-bank ping-pong buffer and streams it out one word per cycle, ascending, over a valid/ready interface with a last marker. It also checks that each captured frame is non-decreasing and raises a sticky error flag if it is not.

## Interface
- `N`, default 10: words per frame; fixed to the sorter width.
- `W`, default 32: word width in bits (`data_t`).
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  the sorter outputs hold a frame to capture.
- `in_ready`  output  1  a free bank is available.
- `sort_0` … `sort_9`  input  W each  sorted frame, `sort_0` smallest.
- `out_data`  output  W  current output word.
- `out_valid`  output  1  `out_data` is valid.
- `out_ready`  input  1  consumer accepts the word.
- `out_last`  output  1  current word is index N-1 of its frame.
- `out_idx`  output  4  index 0..N-1 of the current word within its frame.
- `order_err`  output  1  sticky; set if any captured frame was not non-decreasing.

## Operation
- Storage: two banks of N×W registers, plus `wr_ptr`, `rd_ptr` (1 bit each), `count` (0..2) and `idx` (0..N-1).
- `in_ready = (count != 2)`. It is a function of registered state only; there is no combinational path from `out_ready`.
- Capture occurs when `in_valid && in_ready`:
  - bank[`wr_ptr`] loads `sort_0..sort_9`;
  - `wr_ptr` toggles;
  - `count` increments, unless a frame completes in the same cycle.
- Drain:
  - `out_valid = (count != 0)`;
  - `out_data = bank[rd_ptr][idx]`;
  - `out_last = out_valid && idx == N-1`;
  - `out_idx = idx`.
- Beat occurs when `out_valid && out_ready`:
  - if `idx < N-1`, `idx` increments;
  - otherwise `idx` returns to 0, `rd_ptr` toggles and `count` decrements, unless a capture happens in the same cycle.
- Capture and final beat in the same cycle: `count` is unchanged and both pointers toggle. The capture always targets the bank that is not being read, so no hazard arises.
- `out_valid && !out_ready`: `out_data`, `out_idx` and `out_last` hold stable.
- Order check on capture: if any `sort_k > sort_{k+1}` (unsigned compare, k = 0..N-2), `order_err` is set on the next edge. The frame is still buffered and drained unchanged.
- Unsigned compare only; no arithmetic on data.

## Timing
- Reset values: `count = 0`, `idx = 0`, `wr_ptr = rd_ptr = 0`, both banks all-zero, `order_err = 0`.
- Outputs after reset: `out_valid = 0`, `out_last = 0`, `out_data = 0`, `out_idx = 0`, `in_ready = 1`.
- Latency: a capture at edge t into an empty buffer gives `out_valid = 1` with `idx = 0` in the cycle after t.
- Throughput: N output cycles per frame with `out_ready` held high. Capture of the next frame overlaps the drain of the current one.
- Back-to-back: with both banks full, `in_ready` drops. It rises the cycle after the final beat of the older frame.
- Reset mid-frame: any partial drain and all buffered frames are discarded. The state returns to reset values on the edge where `rst` is sampled high, and `in_valid` is ignored during that cycle.
- `out_ready` high while `out_valid` is low has no effect.

## Structure
- Shared package `sort_pkg`: `typedef logic [31:0] data_t`; `localparam int N_SORT = 10`; `localparam int IDX_W = 4`.
- One natural sub-module: `sort_frame_bank`, an N×`data_t` register bank with load-enable and read-index mux, instantiated twice.
- Pointer/count control and the order checker live in the top level.

## Test plan
- Reset, then capture frame 1..10 with `out_ready = 1`: out_valid rises one cycle after capture; words 1,2,…,10 appear on consecutive cycles; `out_last` is high only with 10 (`out_idx = 9`); `order_err = 0`.
- Three frames offered back-to-back with `out_ready = 0`: frames A and B are accepted and `in_ready` drops after the second. After releasing `out_ready`, `in_ready` rises the cycle after A's last word; C is captured, and B then C drain with no gap.
- Randomly toggle `out_ready` with 30% stalls: `out_data`/`out_idx` are stable during every stall, no word is lost or duplicated, and the frames reproduce in order.
- Capture on the exact cycle of the final beat of the preceding frame: `count` stays 1, and the new frame's word 0 appears on the next cycle.
- Unsorted frame with `sort_3 = 0x80000000` and `sort_4 = 0x00000001`: `order_err` rises and stays high through later good frames until `rst`. The frame is drained verbatim.
- Assert `rst` while at word 5 of a frame with a second frame buffered: next cycle `out_valid = 0`, `in_ready = 1`, `out_idx = 0`, `out_data = 0`.

Source files
------------

// File: rtl/sort_frame_drain_pkg.sv
// Shared types and constants for the sorting-network output stage.
package sort_pkg;
   typedef logic [31:0] data_t;
   localparam int N_SORT = 10;
   localparam int IDX_W  = 4;
endpackage

// File: rtl/sort_frame_bank.sv
// One frame bank: N words loaded in parallel, read back one word at a time.
module sort_frame_bank
   import sort_pkg::*;
#(
   parameter int N = N_SORT,
   parameter int W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_en,
   input  logic [N-1:0][W-1:0]   load_data,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [W-1:0]          rd_data
);

   logic [W-1:0] bank_reg [N];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_word
         // Each word clears on reset and captures its frame slot on load.
         always_ff @(posedge clk) begin
            if (rst)
               bank_reg[gi] <= '0;
            else if (load_en)
               bank_reg[gi] <= load_data[gi];
         end
      end
   endgenerate

   // Combinational word select; the index never exceeds N-1.
   always_comb begin
      rd_data = bank_reg[rd_idx];
   end

endmodule

// File: rtl/sort_frame_drain.sv
// Ping-pong frame buffer behind the sorter: captures a sorted frame per
// handshake, streams it out ascending, and flags frames that are out of order.
module sort_frame_drain
   import sort_pkg::*;
#(
   parameter int N = N_SORT,
   parameter int W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     sort_0,
   input  logic [W-1:0]     sort_1,
   input  logic [W-1:0]     sort_2,
   input  logic [W-1:0]     sort_3,
   input  logic [W-1:0]     sort_4,
   input  logic [W-1:0]     sort_5,
   input  logic [W-1:0]     sort_6,
   input  logic [W-1:0]     sort_7,
   input  logic [W-1:0]     sort_8,
   input  logic [W-1:0]     sort_9,
   output logic [W-1:0]     out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic [IDX_W-1:0] out_idx,
   output logic             order_err
);

   logic [N-1:0][W-1:0] frame;
   logic [N-2:0]        viol;
   logic [IDX_W-1:0]    idx_reg, idx_next;
   logic [1:0]          count_reg, count_next;
   logic                wr_ptr_reg, wr_ptr_next;
   logic                rd_ptr_reg, rd_ptr_next;
   logic                order_err_reg, order_err_next;
   logic                cap, beat, last_beat;
   logic [W-1:0]        rd_data0, rd_data1;

   assign frame[0] = sort_0;
   assign frame[1] = sort_1;
   assign frame[2] = sort_2;
   assign frame[3] = sort_3;
   assign frame[4] = sort_4;
   assign frame[5] = sort_5;
   assign frame[6] = sort_6;
   assign frame[7] = sort_7;
   assign frame[8] = sort_8;
   assign frame[9] = sort_9;

   // Adjacent-pair unsigned order check across the incoming frame.
   generate
      for (genvar gi = 0; gi < N - 1; gi++) begin : g_chk
         assign viol[gi] = frame[gi] > frame[gi+1];
      end
   endgenerate

   assign in_ready  = (count_reg != 2'd2);
   assign out_valid = (count_reg != 2'd0);
   assign cap       = in_valid && in_ready;
   assign beat      = out_valid && out_ready;
   assign last_beat = beat && (idx_reg == IDX_W'(N - 1));

   // Capture always goes to the bank the write pointer selects, which is
   // never the bank being drained unless the buffer is empty.
   sort_frame_bank #(.N(N), .W(W)) u_bank0 (
      .clk       (clk),
      .rst       (rst),
      .load_en   (cap && !wr_ptr_reg),
      .load_data (frame),
      .rd_idx    (idx_reg),
      .rd_data   (rd_data0)
   );

   sort_frame_bank #(.N(N), .W(W)) u_bank1 (
      .clk       (clk),
      .rst       (rst),
      .load_en   (cap && wr_ptr_reg),
      .load_data (frame),
      .rd_idx    (idx_reg),
      .rd_data   (rd_data1)
   );

   // Control state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_reg       <= '0;
         count_reg     <= '0;
         wr_ptr_reg    <= 1'b0;
         rd_ptr_reg    <= 1'b0;
         order_err_reg <= 1'b0;
      end else begin
         idx_reg       <= idx_next;
         count_reg     <= count_next;
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         order_err_reg <= order_err_next;
      end
   end

   // Next-state: word index, occupancy, pointers and sticky error.
   always_comb begin
      idx_next       = idx_reg;
      count_next     = count_reg;
      wr_ptr_next    = wr_ptr_reg ^ cap;
      rd_ptr_next    = rd_ptr_reg ^ last_beat;
      order_err_next = order_err_reg | (cap && (|viol));
      if (beat)
         idx_next = last_beat ? '0 : idx_reg + IDX_W'(1);
      case ({cap, last_beat})
         2'b10:   count_next = count_reg + 2'd1;
         2'b01:   count_next = count_reg - 2'd1;
         default: count_next = count_reg;
      endcase
   end

   // Output decode from registered state.
   always_comb begin
      out_data  = rd_ptr_reg ? rd_data1 : rd_data0;
      out_idx   = idx_reg;
      out_last  = out_valid && (idx_reg == IDX_W'(N - 1));
      order_err = order_err_reg;
   end

endmodule
